conv_weight_buffer_pp: RTL
==========================

Name: conv_weight_buffer_pp

Overview:
Parametrised KxK convolution weight buffer with one streamed load port and a ping-pong (double-buffered) bank pair per kernel position. The next layer's weights load into the shadow half while the PE array reads the active half. It packs narrow input beats into full PE-width words and generates all write addresses and bank selects internally. It sits between the weight DMA stream and the KxK MAC array.

Parameters:
KERNEL_NUM, 9, kernel positions (1 for 1x1, 9 for 3x3); one bank per position.
CH_IN, 16, input channels per PE word.
CH_OUT, 8, output channels per PE word.
DATA_W, 8, weight element width.
IN_W, 128, load stream beat width; WORD_W = CH_OUT*CH_IN*DATA_W must be an integer multiple of IN_W.
ADDR_W, 10, per-half word address width; each half holds 2^ADDR_W words per bank.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
load_start  in  1  pulse; begins a shadow-half load.
load_depth  in  ADDR_W+1  words per bank to load; legal range 1..2^ADDR_W.
s_data  in  IN_W  weight beat.
s_valid  in  1  beat valid.
s_ready  out  1  beat accepted when s_valid & s_ready.
load_busy  out  1  high while in LOAD.
load_done  out  1  one-cycle pulse after the last word is written.
load_err  out  1  one-cycle pulse when load_start is rejected.
shadow_full  out  1  shadow half holds a complete, unswapped load.
swap  in  1  pulse; request active/shadow exchange.
active_sel  out  1  which half the read port addresses.
rd_en  in  1  read request.
rd_addr  in  ADDR_W  word address within the active half.
rd_valid  out  1  rd_data valid.
rd_data  out  KERNEL_NUM*WORD_W  kernel k occupies slice [k*WORD_W +: WORD_W].

Behaviour:
- Reset values: s_ready=0, load_busy=0, load_done=0, load_err=0, shadow_full=0, active_sel=0, rd_valid=0, rd_data=0. Beat, kernel and address counters clear. RAM contents are undefined.
- FSM states: IDLE, LOAD, FIN.
  - IDLE->LOAD on load_start when load_depth is legal and shadow_full=0 (after any same-cycle swap). Latch load_depth; clear counters.
  - Otherwise load_start pulses load_err next cycle and the FSM stays in IDLE.
  - load_start in LOAD or FIN is ignored; no error.
- LOAD:
  - s_ready=1.
  - Beats are packed LSB-first into a WORD_W register; beat 0 goes to bits [IN_W-1:0].
  - On accepting beat BEATS-1 (BEATS=WORD_W/IN_W), write the assembled word to bank kcnt at physical address {~active_sel, acnt} in the same cycle, then increment kcnt.
  - When kcnt wraps at KERNEL_NUM-1, increment acnt.
  - Stream order is address-major, kernel-minor.
  - The final write (acnt=depth-1, kcnt=KERNEL_NUM-1) moves the FSM to FIN; s_ready drops on that edge.
  - s_valid=0 stalls all counters, with no timeout.
- FIN: one cycle; load_done=1, shadow_full set; return to IDLE.
- Swap:
  - Accepted when swap=1, shadow_full=1 and the state is not LOAD/FIN.
  - active_sel toggles and shadow_full clears on the same edge.
  - A rejected swap is silently dropped.
- Swap + load_start in the same IDLE cycle with shadow_full=1: both accepted. The load targets the newly freed half (the old active half).
- Read path:
  - Latency 2: RAM output register, then output register.
  - rd_valid follows rd_en by 2 cycles.
  - The half is sampled at rd_en time; a read issued in the swap cycle uses the pre-swap active_sel.
  - Reads are back-to-back, one per cycle, at full throughput.
- Read/write conflicts: reads never address the shadow half, so read and write never collide.
- rd_data holds its value when rd_valid=0.
- Reset mid-LOAD: immediate return to IDLE. The partial load is discarded, shadow_full=0, active_sel=0.

Decomposition:
- Shared parameter header: DATA_W and IN_W defaults, derived WORD_W and BEATS macros, FSM state encodings.
- Sub-module weight_bank_ram:
  - Simple dual-port, depth 2^(ADDR_W+1), width WORD_W.
  - Registered read.
  - KERNEL_NUM instances in a generate loop.

Test Plan:
- Reset, then load_depth=2 with 144 beats (beat n = n replicated): load_done pulses once; shadow_full=1; s_ready=0 after beat 143. Swap, then read addr 1: kernel 4 slice holds beats 104..111.
- Ping-pong overlap: read half 0 continuously while loading half 1 with distinct data. All reads return half-0 data. After swap, the first read returns half-1 data 2 cycles after rd_en.
- Rejections: load_depth=0 gives load_err. load_start while shadow_full=1 without swap gives load_err. Swap during LOAD leaves active_sel unchanged.
- Same-cycle swap+load_start in IDLE with shadow_full=1: active_sel toggles, load_busy=1 next cycle, no load_err.
- s_valid toggled 50% randomly during a load_depth=1 load: word contents are identical to the gap-free load; load_done pulses after beat 71.
- rst asserted at beat 30 of a load: all outputs return to reset values next cycle. A subsequent full load completes correctly.

Source files
------------

// File: rtl/conv_weight_buffer_pp_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// conv_weight_buffer_pp_pkg : shared defaults, width helpers, FSM codes. Rev 1.0
//----------------------------------------------------------------------------
package conv_weight_buffer_pp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IN_W_DEF   = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic int word_width(input int ch_out, input int ch_in, input int data_w);
    return ch_out * ch_in * data_w;
  endfunction

  function automatic int beat_count(input int word_w, input int in_w);
    return word_w / in_w;
  endfunction

  // Counters keep at least one bit so a single-entry range stays legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_weight_buffer_pp_weight_bank_ram.sv
`default_nettype none
//----------------------------------------------------------------------------
// weight_bank_ram : simple dual-port RAM, registered read, both halves. Rev 1.0
//----------------------------------------------------------------------------
module weight_bank_ram
  import conv_weight_buffer_pp_pkg::*;
#(
  parameter int WORD_W = 1024,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/conv_weight_buffer_pp.sv
`default_nettype none
//----------------------------------------------------------------------------
// conv_weight_buffer_pp : ping-pong KxK weight buffer with packed load stream. Rev 1.0
//----------------------------------------------------------------------------
module conv_weight_buffer_pp
  import conv_weight_buffer_pp_pkg::*;
#(
  parameter int KERNEL_NUM = 9,
  parameter int CH_IN      = 16,
  parameter int CH_OUT     = 8,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int IN_W       = IN_W_DEF,
  parameter int ADDR_W     = 10
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       load_start,
  input  logic [ADDR_W:0]                            load_depth,
  input  logic [IN_W-1:0]                            s_data,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  output logic                                       load_busy,
  output logic                                       load_done,
  output logic                                       load_err,
  output logic                                       shadow_full,
  input  logic                                       swap,
  output logic                                       active_sel,
  input  logic                                       rd_en,
  input  logic [ADDR_W-1:0]                          rd_addr,
  output logic                                       rd_valid,
  output logic [KERNEL_NUM*CH_OUT*CH_IN*DATA_W-1:0]  rd_data
);

  localparam int WORD_W = word_width(CH_OUT, CH_IN, DATA_W);
  localparam int BEATS  = beat_count(WORD_W, IN_W);
  localparam int BCNT_W = cnt_width(BEATS);
  localparam int KCNT_W = cnt_width(KERNEL_NUM);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEATS - 1);
  localparam logic [KCNT_W-1:0] KERN_LAST = KCNT_W'(KERNEL_NUM - 1);
  localparam logic [ADDR_W:0]   DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state, state_nxt;
  logic [BCNT_W-1:0] bcnt;
  logic [KCNT_W-1:0] kcnt;
  logic [ADDR_W-1:0] acnt, depth_m1, depth_dec;
  logic [WORD_W-1:0] pack, wr_word;
  logic              depth_ok, swap_ok, start_ok;
  logic              beat_fire, word_fire, last_word;
  logic              rd_pipe;
  logic [WORD_W-1:0] bank_q [KERNEL_NUM];

  // 2^ADDR_W has all-zero low bits, so the truncated decrement is still depth-1.
  assign depth_dec = load_depth[ADDR_W-1:0] - 1'b1;
  assign depth_ok  = (load_depth != '0) && (load_depth <= DEPTH_MAX);
  assign swap_ok   = swap && shadow_full && (state == ST_IDLE);
  assign start_ok  = load_start && (state == ST_IDLE) && depth_ok && (!shadow_full || swap_ok);
  assign beat_fire = s_valid && (state == ST_LOAD);
  assign word_fire = beat_fire && (bcnt == BEAT_LAST);
  assign last_word = word_fire && (kcnt == KERN_LAST) && (acnt == depth_m1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok)  state_nxt = ST_LOAD;
      ST_LOAD: if (last_word) state_nxt = ST_FIN;
      ST_FIN:                 state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state == ST_LOAD);
    load_busy = (state == ST_LOAD);
    load_done = (state == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_err    <= 1'b0;
      shadow_full <= 1'b0;
      active_sel  <= 1'b0;
      bcnt        <= '0;
      kcnt        <= '0;
      acnt        <= '0;
      depth_m1    <= '0;
    end else begin
      load_err <= load_start && (state == ST_IDLE) && !start_ok;
      if (swap_ok) active_sel <= ~active_sel;
      if (state == ST_FIN)   shadow_full <= 1'b1;
      else if (swap_ok)      shadow_full <= 1'b0;
      if (start_ok) begin
        depth_m1 <= depth_dec;
        bcnt     <= '0;
        kcnt     <= '0;
        acnt     <= '0;
      end else if (beat_fire) begin
        bcnt <= (bcnt == BEAT_LAST) ? '0 : bcnt + 1'b1;
        if (word_fire) begin
          if (kcnt == KERN_LAST) begin
            kcnt <= '0;
            acnt <= acnt + 1'b1;
          end else begin
            kcnt <= kcnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) begin
      for (int b = 0; b < BEATS; b++) begin
        if (bcnt == BCNT_W'(b)) pack[b*IN_W +: IN_W] <= s_data;
      end
    end
  end

  // The final beat bypasses the pack register so the word is written on its accept edge.
  always_comb begin
    wr_word = pack;
    wr_word[WORD_W-1 -: IN_W] = s_data;
  end

  for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_bank
    weight_bank_ram #(
      .WORD_W (WORD_W),
      .AW     (ADDR_W + 1)
    ) u_ram (
      .clk   (clk),
      .we    (word_fire && (kcnt == KCNT_W'(k))),
      .waddr ({~active_sel, acnt}),
      .wdata (wr_word),
      .re    (rd_en),
      .raddr ({active_sel, rd_addr}),
      .rdata (bank_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= rd_en;
      rd_valid <= rd_pipe;
      if (rd_pipe) begin
        for (int k = 0; k < KERNEL_NUM; k++) rd_data[k*WORD_W +: WORD_W] <= bank_q[k];
      end
    end
  end

endmodule
`default_nettype wire
